// File: rtl/dac_spi_pkg.sv
// Shared types and constants for the multi-channel DAC SPI configuration port.
// Instruction byte layout: read/write flag on top, 7-bit register address below.
package dac_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_IOUP_WAIT,
    ST_IOUP_PULSE
  } state_e;

  localparam int INSTR_RW_BIT   = 7;
  localparam int INSTR_ADDR_MSB = 6;
  localparam int INSTR_ADDR_LSB = 0;
  localparam int IOUP_W_DEF     = 4;

  function automatic logic [7:0] instr_byte(
    input logic       rw,
    input logic [6:0] addr
  );
    logic [7:0] b;
    b = '0;
    b[INSTR_RW_BIT] = rw;
    b[INSTR_ADDR_MSB:INSTR_ADDR_LSB] = addr;
    return b;
  endfunction

endpackage

// File: rtl/dac_spi_clkdiv.sv
// SPI clock generator: mode-0 clock (idle low) with one-cycle rise/fall strobes.
// Held in reset-like state (clock low, counter cleared) whenever en_i is low.
module dac_spi_clkdiv #(
  parameter int CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic spi_clk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          clk_q, clk_d;
  logic          tick;

  assign tick   = en_i && (cnt_q == TERM);
  assign rise_o = tick && !clk_q;
  assign fall_o = tick && clk_q;
  assign spi_clk_o = clk_q;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    clk_d = clk_q;
    if (!en_i) begin
      cnt_d = '0;
      clk_d = 1'b0;
    end else if (tick) begin
      cnt_d = '0;
      clk_d = ~clk_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      clk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      clk_q <= clk_d;
    end
  end

endmodule

// File: rtl/dac_spi_multi_cfg.sv
// Multi-channel DAC SPI register access with optional io_update pulse.
// Read support is compiled in only when DAC_SPI_READ_EN is defined.
module dac_spi_multi_cfg
  import dac_spi_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int MAX_BYTES = 8,
  parameter int CLK_DIV   = 2,
  parameter int IOUP_W    = IOUP_W_DEF
) (
  input  logic                   cfg_spi_clk,
  input  logic                   cfg_rst_in,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic                   cfg_rw,
  input  logic [2:0]             cfg_ch,
  input  logic [6:0]             cfg_addr,
  input  logic [3:0]             cfg_len,
  input  logic [8*MAX_BYTES-1:0] cfg_data,
  input  logic                   cfg_ioup,
  input  logic [15:0]            ioup_delay,
  output logic                   spi_clk,
  output logic [NUM_CH-1:0]      spi_cs_n,
  output logic                   spi_sdi,
  input  logic                   spi_sdo,
  output logic [NUM_CH-1:0]      io_update,
  output logic [8*MAX_BYTES-1:0] rd_data,
  output logic                   rd_valid,
  output logic                   busy,
  output logic                   err
);

  localparam int DW = 8 * MAX_BYTES;
  localparam int FW = DW + 8;
  localparam logic [3:0]  MAXB    = 4'(MAX_BYTES);
  localparam logic [3:0]  NCH     = 4'(NUM_CH);
  localparam logic [15:0] DIV_M1  = 16'(CLK_DIV - 1);
  localparam logic [15:0] IOUP_M1 = 16'(IOUP_W - 1);

  state_e              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [6:0]          bit_q, bit_d;
  logic [FW-1:0]       sh_q, sh_d;
  logic                sdi_q, sdi_d;
  logic [NUM_CH-1:0]   cs_n_q, cs_n_d;
  logic [NUM_CH-1:0]   iou_q, iou_d;
  logic                err_q, err_d;
  logic [2:0]          ch_q, ch_d;
  logic [3:0]          len_q, len_d;
  logic                ioup_q, ioup_d;
  logic [15:0]         dly_q, dly_d;

  logic                bad_req;
  logic [6:0]          shamt;
  logic [DW-1:0]       wdata;
  logic [FW-1:0]       frame;
  logic [6:0]          nbits;
  logic [NUM_CH-1:0]   ch_oh;
  logic                sck_rise, sck_fall;

`ifdef DAC_SPI_READ_EN
  logic                rw_q, rw_d;
  logic [DW-1:0]       rsh_q, rsh_d;
  logic [DW-1:0]       rdd_q, rdd_d;
  logic                rdv_q, rdv_d;
`else
  logic                unused_sdo;
  assign unused_sdo = spi_sdo;
`endif

  dac_spi_clkdiv #(
    .CLK_DIV(CLK_DIV)
  ) u_clkdiv (
    .clk_i    (cfg_spi_clk),
    .rst_i    (cfg_rst_in),
    .en_i     (state_q == ST_SHIFT),
    .spi_clk_o(spi_clk),
    .rise_o   (sck_rise),
    .fall_o   (sck_fall)
  );

  always_comb begin
    bad_req = (cfg_len == 4'd0) || (cfg_len > MAXB) ||
              ({1'b0, cfg_ch} >= NCH);
`ifndef DAC_SPI_READ_EN
    bad_req = bad_req || cfg_rw;
`endif
  end

  // Data is left-justified in the frame so the shifter always drains from the top.
  assign shamt = {MAXB - cfg_len, 3'b000};
  assign wdata = cfg_rw ? '0 : (cfg_data << shamt);
  assign frame = {instr_byte(cfg_rw, cfg_addr), wdata};
  assign nbits = {len_q + 4'd1, 3'b000};
  assign ch_oh = NUM_CH'(1) << ch_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    sdi_d   = sdi_q;
    cs_n_d  = cs_n_q;
    iou_d   = iou_q;
    err_d   = 1'b0;
    ch_d    = ch_q;
    len_d   = len_q;
    ioup_d  = ioup_q;
    dly_d   = dly_q;
`ifdef DAC_SPI_READ_EN
    rw_d    = rw_q;
    rsh_d   = rsh_q;
    rdd_d   = rdd_q;
    rdv_d   = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          ch_d   = cfg_ch;
          len_d  = cfg_len;
          ioup_d = cfg_ioup & ~cfg_rw;
          dly_d  = ioup_delay;
`ifdef DAC_SPI_READ_EN
          rw_d   = cfg_rw;
`endif
          if (bad_req) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_SETUP;
            cnt_d   = '0;
            bit_d   = '0;
            cs_n_d  = ~(NUM_CH'(1) << cfg_ch);
            sdi_d   = frame[FW-1];
            sh_d    = {frame[FW-2:0], 1'b0};
`ifdef DAC_SPI_READ_EN
            rsh_d   = '0;
`endif
          end
        end
      end
      ST_SETUP: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == DIV_M1) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
`ifdef DAC_SPI_READ_EN
        if (sck_rise && (bit_q >= 7'd8)) begin
          rsh_d = {rsh_q[DW-2:0], spi_sdo};
        end
`endif
        if (sck_fall) begin
          bit_d = bit_q + 7'd1;
          if (bit_q + 7'd1 == nbits) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            sdi_d   = 1'b0;
          end else begin
            sdi_d = sh_q[FW-1];
            sh_d  = {sh_q[FW-2:0], 1'b0};
          end
        end
      end
      ST_HOLD: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == DIV_M1) begin
          cs_n_d  = '1;
          cnt_d   = '0;
          state_d = ST_IDLE;
`ifdef DAC_SPI_READ_EN
          if (rw_q) begin
            rdd_d = rsh_q;
            rdv_d = 1'b1;
          end
`endif
          if (ioup_q) begin
            if (dly_q == 16'd0) begin
              iou_d   = ch_oh;
              state_d = ST_IOUP_PULSE;
            end else begin
              state_d = ST_IOUP_WAIT;
            end
          end
        end
      end
      ST_IOUP_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == dly_q - 16'd1) begin
          iou_d   = ch_oh;
          cnt_d   = '0;
          state_d = ST_IOUP_PULSE;
        end
      end
      ST_IOUP_PULSE: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == IOUP_M1) begin
          iou_d   = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge cfg_spi_clk or posedge cfg_rst_in) begin
    if (cfg_rst_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      sdi_q   <= 1'b0;
      cs_n_q  <= '1;
      iou_q   <= '0;
      err_q   <= 1'b0;
      ch_q    <= '0;
      len_q   <= '0;
      ioup_q  <= 1'b0;
      dly_q   <= '0;
`ifdef DAC_SPI_READ_EN
      rw_q    <= 1'b0;
      rsh_q   <= '0;
      rdd_q   <= '0;
      rdv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      sdi_q   <= sdi_d;
      cs_n_q  <= cs_n_d;
      iou_q   <= iou_d;
      err_q   <= err_d;
      ch_q    <= ch_d;
      len_q   <= len_d;
      ioup_q  <= ioup_d;
      dly_q   <= dly_d;
`ifdef DAC_SPI_READ_EN
      rw_q    <= rw_d;
      rsh_q   <= rsh_d;
      rdd_q   <= rdd_d;
      rdv_q   <= rdv_d;
`endif
    end
  end

`ifdef DAC_SPI_READ_EN
  assign rd_data  = rdd_q;
  assign rd_valid = rdv_q;
`else
  assign rd_data  = '0;
  assign rd_valid = 1'b0;
`endif

  assign spi_cs_n  = cs_n_q;
  assign spi_sdi   = sdi_q;
  assign io_update = iou_q;
  assign err       = err_q;
  assign cfg_ready = (state_q == ST_IDLE);
  assign busy      = ~cfg_ready;

endmodule

// File: tb/tb_dac_spi_multi_cfg.sv
// Self-checking bench for dac_spi_multi_cfg: vector table, SPI frame scoreboard,
// io_update timing, error rejection and mid-transaction reset.
module tb_dac_spi_multi_cfg;

  localparam int NUM_CH    = 4;
  localparam int MAX_BYTES = 8;
  localparam int CLK_DIV   = 2;
  localparam int IOUP_W    = 4;
`ifdef DAC_SPI_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        cfg_rw;
  logic [2:0]  cfg_ch;
  logic [6:0]  cfg_addr;
  logic [3:0]  cfg_len;
  logic [63:0] cfg_data;
  logic        cfg_ioup;
  logic [15:0] ioup_delay;
  logic        spi_clk;
  logic [3:0]  spi_cs_n;
  logic        spi_sdi;
  logic        spi_sdo;
  logic [3:0]  io_update;
  logic [63:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        err;

  always #5 clk = ~clk;

  dac_spi_multi_cfg #(
    .NUM_CH(NUM_CH), .MAX_BYTES(MAX_BYTES),
    .CLK_DIV(CLK_DIV), .IOUP_W(IOUP_W)
  ) dut (
    .cfg_spi_clk(clk), .cfg_rst_in(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_rw(cfg_rw), .cfg_ch(cfg_ch),
    .cfg_addr(cfg_addr), .cfg_len(cfg_len),
    .cfg_data(cfg_data), .cfg_ioup(cfg_ioup),
    .ioup_delay(ioup_delay), .spi_clk(spi_clk),
    .spi_cs_n(spi_cs_n), .spi_sdi(spi_sdi),
    .spi_sdo(spi_sdo), .io_update(io_update),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .err(err)
  );

  typedef struct {
    logic        rw;
    logic [2:0]  ch;
    logic [6:0]  addr;
    logic [3:0]  len;
    logic [63:0] data;
    logic        ioup;
    logic [15:0] dly;
    logic [63:0] resp;
    logic        bad;
  } vec_t;

  typedef struct {
    logic [3:0]  mask;
    int          nbits;
    logic [71:0] stream;
    logic        rd;
    logic [63:0] resp;
    int          len;
  } exp_t;

  exp_t        exp_q[$];
  vec_t        vt[9];
  int          n_chk = 0;
  int          n_fail = 0;

  logic        prev_clk = 1'b0;
  logic        prev_sdi = 1'b0;
  logic        active = 1'b0;
  logic        rel_now = 1'b0;
  logic [71:0] obs = '0;
  logic [3:0]  mask_seen = '1;
  int          nrise = 0;
  int          mbad = 0;
  int          sdi_bad = 0;
  int          rdv_cnt = 0;

  task automatic chk(input string name, input logic [71:0] act,
                     input logic [71:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic frame_done();
    exp_t e;
    if (exp_q.size() == 0) begin
      timeout("unexpected_frame");
      return;
    end
    e = exp_q.pop_front();
    chk("frame_cs", 72'(mask_seen), 72'(e.mask));
    chk("frame_sck_periods", 72'(nrise), 72'(e.nbits));
    chk("frame_sdi", obs, e.stream);
    chk("frame_cs_stable", 72'(mbad), 72'(0));
    chk("frame_sdi_stable", 72'(sdi_bad), 72'(0));
    if (e.rd) begin
      chk("rd_valid_at_cs", 72'(rd_valid), 72'(1));
      chk("rd_data", 72'(rd_data), 72'(e.resp));
    end
  endtask

  // Samples the bus on the falling system-clock edge and plays the DAC's sdo.
  task automatic tick();
    int k;
    @(negedge clk);
    rel_now = 1'b0;
    if (rd_valid) rdv_cnt++;
    if (rst) begin
      active = 1'b0;
      prev_clk = 1'b0;
      nrise = 0;
      spi_sdo = 1'b0;
      return;
    end
    if (spi_cs_n != 4'hF) begin
      if (!active) begin
        active = 1'b1;
        nrise = 0;
        obs = '0;
        mask_seen = spi_cs_n;
        mbad = 0;
        sdi_bad = 0;
      end else if (spi_cs_n != mask_seen) begin
        mbad++;
      end
    end
    if (spi_clk && prev_clk && spi_sdi != prev_sdi) sdi_bad++;
    if (spi_clk && !prev_clk) begin
      obs = {obs[70:0], spi_sdi};
      nrise++;
    end
    prev_clk = spi_clk;
    prev_sdi = spi_sdi;
    if (active && spi_cs_n == 4'hF) begin
      active = 1'b0;
      rel_now = 1'b1;
      frame_done();
    end
    spi_sdo = 1'b0;
    if (active && exp_q.size() > 0) begin
      if (exp_q[0].rd && nrise >= 8 && nrise < 8 + 8 * exp_q[0].len) begin
        k = 8 * exp_q[0].len - 1 - (nrise - 8);
        spi_sdo = exp_q[0].resp[k];
      end
    end
  endtask

  task automatic drive(input vec_t v);
    cfg_valid  = 1'b1;
    cfg_rw     = v.rw;
    cfg_ch     = v.ch;
    cfg_addr   = v.addr;
    cfg_len    = v.len;
    cfg_data   = v.data;
    cfg_ioup   = v.ioup;
    ioup_delay = v.dly;
  endtask

  task automatic push_exp(input vec_t v);
    exp_t        e;
    logic [63:0] dp;
    int          nb;
    nb = 8 * int'(v.len);
    dp = v.rw ? 64'd0 : v.data;
    if (v.len < 4'd8) dp = dp & ((64'd1 << nb) - 64'd1);
    e.mask = 4'hF;
    e.mask[v.ch[1:0]] = 1'b0;
    e.nbits = nb + 8;
    e.stream = ({64'd0, v.rw, v.addr} << nb) | {8'd0, dp};
    e.rd = v.rw;
    e.resp = v.resp;
    e.len = int'(v.len);
    exp_q.push_back(e);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 5000; i++) begin
      if (cfg_ready) return;
      tick();
    end
    timeout("wait_ready");
  endtask

  task automatic do_vec(input string name, input vec_t v);
    logic [3:0] m;
    logic       io;
    int rel_at, first, hi, other, n, rdv0, bad_io;
    bit done;
    wait_ready();
    drive(v);
    if (!v.bad) push_exp(v);
    tick();
    cfg_valid = 1'b0;
    if (v.bad) begin
      chk({name, "_err_pulse"}, 72'(err), 72'(1));
      chk({name, "_err_idle"}, 72'(busy), 72'(0));
      tick();
      chk({name, "_err_once"}, 72'(err), 72'(0));
      bad_io = 0;
      for (int i = 0; i < 8; i++) begin
        if (spi_cs_n != 4'hF || spi_clk || spi_sdi || err) bad_io++;
        tick();
      end
      chk({name, "_no_spi"}, 72'(bad_io), 72'(0));
      return;
    end
    m = 4'hF;
    m[v.ch[1:0]] = 1'b0;
    io = v.ioup && !v.rw;
    chk({name, "_cs_setup"}, 72'(spi_cs_n), 72'(m));
    rel_at = -1; first = -1; hi = 0; other = 0; n = 0;
    rdv0 = rdv_cnt; done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      n++;
      if (rel_now && rel_at < 0) rel_at = n;
      if (io_update[v.ch[1:0]]) begin
        if (first < 0) first = n;
        hi++;
      end
      if ((io_update & m) != 4'h0) other++;
      if (cfg_ready && rel_at >= 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      timeout({name, "_complete"});
      return;
    end
    chk({name, "_frames_left"}, 72'(exp_q.size()), 72'(0));
    chk({name, "_ready_lat"}, 72'(n - rel_at),
        72'(io ? int'(v.dly) + IOUP_W : 0));
    chk({name, "_ioup_width"}, 72'(hi), 72'(io ? IOUP_W : 0));
    if (io) chk({name, "_ioup_delay"}, 72'(first - rel_at), 72'(v.dly));
    chk({name, "_ioup_other"}, 72'(other), 72'(0));
    chk({name, "_rd_pulses"}, 72'(rdv_cnt - rdv0), 72'(v.rw ? 1 : 0));
  endtask

  initial begin
    vec_t vr;
    bit   hit;
    vt[0] = '{1'b0, 3'd2, 7'h0E, 4'd8, 64'h0123456789ABCDEF, 1'b0, 16'd0,  64'd0, 1'b0};
    vt[1] = '{1'b0, 3'd2, 7'h0E, 4'd8, 64'h0123456789ABCDEF, 1'b1, 16'd10, 64'd0, 1'b0};
    vt[2] = '{1'b0, 3'd1, 7'h55, 4'd1, 64'h00000000000000A7, 1'b0, 16'd0,  64'd0, 1'b0};
    vt[3] = '{1'b0, 3'd3, 7'h7F, 4'd3, 64'hFFFF000000123456, 1'b0, 16'd0,  64'd0, 1'b0};
    vt[4] = '{1'b0, 3'd1, 7'h10, 4'd0, 64'h1234,             1'b0, 16'd0,  64'd0, 1'b1};
    vt[5] = '{1'b0, 3'd5, 7'h10, 4'd2, 64'h1234,             1'b0, 16'd0,  64'd0, 1'b1};
    vt[6] = '{1'b0, 3'd0, 7'h10, 4'd9, 64'h1234,             1'b0, 16'd0,  64'd0, 1'b1};
    vt[7] = '{1'b1, 3'd0, 7'h01, 4'd4, 64'hDEADBEEFDEADBEEF, 1'b1, 16'd3,
              64'h00000000A5C30F96, !READ_EN};
    vt[8] = '{1'b0, 3'd0, 7'h3C, 4'd2, 64'h000000000000C35A, 1'b1, 16'd0,  64'd0, 1'b0};

    rst = 1'b1;
    cfg_valid = 1'b0; cfg_rw = 1'b0; cfg_ch = '0; cfg_addr = '0;
    cfg_len = '0; cfg_data = '0; cfg_ioup = 1'b0; ioup_delay = '0;
    spi_sdo = 1'b0;
    tick();
    tick();
    chk("rst_cs_n", 72'(spi_cs_n), 72'(4'hF));
    chk("rst_spi_clk", 72'(spi_clk), 72'(0));
    chk("rst_sdi", 72'(spi_sdi), 72'(0));
    chk("rst_io_update", 72'(io_update), 72'(0));
    chk("rst_rd_data", 72'(rd_data), 72'(0));
    chk("rst_rd_valid", 72'(rd_valid), 72'(0));
    chk("rst_err", 72'(err), 72'(0));
    chk("rst_ready", 72'(cfg_ready), 72'(1));
    chk("rst_busy", 72'(busy), 72'(0));
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      do_vec($sformatf("vec%0d", i), vt[i]);
    end

    // Abort a write mid-frame, then check a fresh write right after release.
    vr = '{1'b0, 3'd1, 7'h22, 4'd8, 64'hFEDCBA9876543210, 1'b0, 16'd0, 64'd0, 1'b0};
    wait_ready();
    drive(vr);
    push_exp(vr);
    tick();
    cfg_valid = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (nrise >= 20) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
    if (!hit) timeout("reach_bit20");
    chk("pre_rst_busy", 72'(busy), 72'(1));
    #1 rst = 1'b1;
    #1;
    chk("midrst_cs_n", 72'(spi_cs_n), 72'(4'hF));
    chk("midrst_spi_clk", 72'(spi_clk), 72'(0));
    chk("midrst_ready", 72'(cfg_ready), 72'(1));
    chk("midrst_busy", 72'(busy), 72'(0));
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    vr = '{1'b0, 3'd3, 7'h0E, 4'd8, 64'h0123456789ABCDEF, 1'b1, 16'd2, 64'd0, 1'b0};
    do_vec("post_rst", vr);

    if (!READ_EN) chk("rd_valid_never", 72'(rdv_cnt), 72'(0));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
